// File: rtl/rtc_bus_arbiter.sv
`timescale 1ns/1ps
// rtc_bus_arbiter: grants the shared RTC bus to the ini/esc/lec engines, schedules periodic reads, drives the bus pins
module rtc_bus_arbiter #(
  parameter int READ_PERIOD = 1000,
  parameter int TIMEOUT     = 255,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_ini,
  input  logic       i_req_esc,
  input  logic       i_req_lec,
  input  logic       i_done_ini,
  input  logic       i_done_esc,
  input  logic       i_done_lec,
  input  logic       i_ad_ini,
  input  logic       i_cs_ini,
  input  logic       i_rd_ini,
  input  logic       i_wr_ini,
  input  logic       i_dir_dat_ini,
  input  logic [7:0] i_direccion_ini,
  input  logic       i_ad_esc,
  input  logic       i_cs_esc,
  input  logic       i_rd_esc,
  input  logic       i_wr_esc,
  input  logic       i_dir_dat_esc,
  input  logic [7:0] i_direccion_esc,
  input  logic       i_ad_lec,
  input  logic       i_cs_lec,
  input  logic       i_rd_lec,
  input  logic       i_wr_lec,
  input  logic       i_dir_dat_lec,
  input  logic [7:0] i_direccion_lec,
  output logic       o_en_ini,
  output logic       o_en_esc,
  output logic       o_en_lec,
  output logic       o_ad,
  output logic       o_cs,
  output logic       o_rd,
  output logic       o_wr,
  output logic       o_dir_dat,
  output logic [7:0] o_direccion,
  output logic       o_busy,
  output logic       o_init_ok,
  output logic       o_err_timeout
);
  localparam int PW = $clog2(READ_PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, G_INI, G_ESC, G_LEC, GAP} state_t;
  state_t r_state, w_pick, w_next;
  logic [PW-1:0] r_per_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic r_ini_pend, r_lec_pend, r_init_ok, r_err_timeout;
  logic w_wrap, w_grant, w_done, w_timeout;
  assign w_wrap    = r_per_cnt == PW'(READ_PERIOD - 1);
  assign w_grant   = o_en_ini | o_en_esc | o_en_lec;
  assign w_done    = (o_en_ini & i_done_ini) | (o_en_esc & i_done_esc) | (o_en_lec & i_done_lec);
  assign w_timeout = w_grant & (r_to_cnt == TW'(TIMEOUT - 1));
  always_comb begin
    w_pick = (r_ini_pend | i_req_ini) ? G_INI :
             !r_init_ok               ? IDLE  :
             i_req_esc                ? G_ESC :
             (r_lec_pend | i_req_lec) ? G_LEC : IDLE;
    w_next = r_state == IDLE ? w_pick :
             r_state == GAP  ? (r_gap_cnt == GW'(GAP_CYCLES - 1) ? w_pick : GAP) :
             (w_done | w_timeout) ? GAP : r_state;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_per_cnt     <= '0;
      r_to_cnt      <= '0;
      r_gap_cnt     <= '0;
      r_ini_pend    <= 1'b1;
      r_lec_pend    <= 1'b0;
      r_init_ok     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_per_cnt     <= w_wrap ? '0 : r_per_cnt + 1'b1;
      r_to_cnt      <= (w_next != r_state) ? '0 : r_to_cnt + 1'b1;
      r_gap_cnt     <= (w_next != r_state) ? '0 : r_gap_cnt + 1'b1;
      r_ini_pend    <= r_ini_pend & !(w_next == G_INI && r_state != G_INI);
      r_lec_pend    <= w_wrap | (r_lec_pend & !(w_next == G_LEC && r_state != G_LEC));
      r_init_ok     <= r_init_ok | (o_en_ini & i_done_ini);
      r_err_timeout <= r_err_timeout | (w_timeout & !w_done);
    end
  end
  assign o_en_ini      = r_state == G_INI;
  assign o_en_esc      = r_state == G_ESC;
  assign o_en_lec      = r_state == G_LEC;
  assign o_busy        = w_grant;
  assign o_init_ok     = r_init_ok;
  assign o_err_timeout = r_err_timeout;
  assign o_ad        = o_en_ini ? i_ad_ini        : o_en_esc ? i_ad_esc        : o_en_lec ? i_ad_lec        : 1'b1;
  assign o_cs        = o_en_ini ? i_cs_ini        : o_en_esc ? i_cs_esc        : o_en_lec ? i_cs_lec        : 1'b1;
  assign o_rd        = o_en_ini ? i_rd_ini        : o_en_esc ? i_rd_esc        : o_en_lec ? i_rd_lec        : 1'b1;
  assign o_wr        = o_en_ini ? i_wr_ini        : o_en_esc ? i_wr_esc        : o_en_lec ? i_wr_lec        : 1'b1;
  assign o_dir_dat   = o_en_ini ? i_dir_dat_ini   : o_en_esc ? i_dir_dat_esc   : o_en_lec ? i_dir_dat_lec   : 1'b0;
  assign o_direccion = o_en_ini ? i_direccion_ini : o_en_esc ? i_direccion_esc : o_en_lec ? i_direccion_lec : 8'h00;
endmodule
